// File: rtl/audio_dma_server_if.sv
// Memory read port shared between the audio DMA server (master) and the
// VRAM/TILE memory arbiter (slave). One read is outstanding at a time.
interface audio_dma_server_if;
  logic        vram_sel_o;
  logic        tile_sel_o;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_data_i;

  modport master (
    output vram_sel_o,
    output tile_sel_o,
    output mem_addr_o,
    input  mem_data_i
  );

  modport slave (
    input  vram_sel_o,
    input  tile_sel_o,
    input  mem_addr_o,
    output mem_data_i
  );
endinterface

// File: rtl/audio_dma_server.sv
// Audio DMA server: round-robin arbiter that serves audio channel sample
// fetches with single-word reads in memory slots the video path leaves free.
// It also generates the per-scanline DMA start strobe.
// Optional macro AUDIO_DMA_STATS_EN adds a saturating underrun counter on
// stat_miss_o. Without the macro, stat_miss_o is tied to zero.
//
// state  | meaning
// IDLE   | waiting for an eligible request in a free memory slot
// ISSUE  | read select and address on the memory port for one cycle
// WAIT   | extra latency cycle, used only when MEM_LAT == 2
// ACK    | capture the read data and pulse the granted channel's ack
module audio_dma_server #(
  parameter int NCHAN   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic                  audio_enable_i,
  input  logic                  line_start_i,
  input  logic                  dma_slot_i,
  output logic                  dma_start_o,
  input  logic [NCHAN-1:0]      chan_fetch_i,
  input  logic [NCHAN-1:0]      chan_tile_i,
  input  logic [NCHAN*16-1:0]   chan_addr_i,
  output logic [NCHAN-1:0]      chan_ack_o,
  output logic [NCHAN*16-1:0]   chan_word_o,
  audio_dma_server_if.master    mem,
  output logic [15:0]           stat_miss_o
);

  localparam int PW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t                r_state;
  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         r_gnt;
  logic                  r_vram_sel;
  logic                  r_tile_sel;
  logic [15:0]           r_mem_addr;
  logic [NCHAN-1:0]      r_ack;
  logic [NCHAN*16-1:0]   r_word;
  logic                  r_dma_start;

  logic [NCHAN-1:0]      w_elig;
  logic                  w_found;
  logic [PW-1:0]         w_gnt;
  logic [PW:0]           w_sum;
  logic [PW-1:0]         w_ptr_nxt;

  // The ack register doubles as the recently-acked mask: it is high exactly
  // in the ack cycle, which covers the requester's registered drop of fetch.
  assign w_elig    = chan_fetch_i & ~r_ack;
  assign w_ptr_nxt = (r_gnt == PW'(NCHAN - 1)) ? '0 : r_gnt + PW'(1);

  // Pick the first eligible channel at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_sum   = '0;
    for (int i = 0; i < NCHAN; i++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(NCHAN)) w_sum = w_sum - (PW+1)'(NCHAN);
      if (!w_found && w_elig[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_sum[PW-1:0];
      end
    end
  end

  // Fetch sequencer; selects, address and acks are all registered here.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_vram_sel <= 1'b0;
      r_tile_sel <= 1'b0;
      r_mem_addr <= '0;
      r_ack      <= '0;
      r_word     <= '0;
    end else begin
      r_ack      <= '0;
      r_vram_sel <= 1'b0;
      r_tile_sel <= 1'b0;
      r_mem_addr <= '0;
      if (!audio_enable_i) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (dma_slot_i && w_found) begin
              r_gnt      <= w_gnt;
              r_vram_sel <= !chan_tile_i[w_gnt];
              r_tile_sel <= chan_tile_i[w_gnt];
              r_mem_addr <= chan_addr_i[16*w_gnt +: 16];
              r_state    <= S_ISSUE;
            end
          end
          S_ISSUE: r_state <= (MEM_LAT == 2) ? S_WAIT : S_ACK;
          S_WAIT:  r_state <= S_ACK;
          S_ACK: begin
            r_word[16*r_gnt +: 16] <= mem.mem_data_i;
            r_ack[r_gnt]           <= 1'b1;
            r_ptr                  <= w_ptr_nxt;
            r_state                <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Per-line start strobe, delayed one cycle from the line pulse.
  always_ff @(posedge clk) begin
    if (!reset_n_i) r_dma_start <= 1'b0;
    else            r_dma_start <= line_start_i && audio_enable_i;
  end

`ifdef AUDIO_DMA_STATS_EN
  logic [15:0] r_miss;

  // Count line starts that find a fetch still unserved; saturates.
  always_ff @(posedge clk) begin
    if (!reset_n_i)
      r_miss <= '0;
    else if (r_dma_start && (|chan_fetch_i) && (r_miss != 16'hFFFF))
      r_miss <= r_miss + 16'd1;
  end

  assign stat_miss_o = r_miss;
`else
  assign stat_miss_o = '0;
`endif

  assign dma_start_o    = r_dma_start;
  assign chan_ack_o     = r_ack;
  assign chan_word_o    = r_word;
  assign mem.vram_sel_o = r_vram_sel;
  assign mem.tile_sel_o = r_tile_sel;
  assign mem.mem_addr_o = r_mem_addr;

endmodule

// File: tb/tb_audio_dma_server.sv
// Directed bench for audio_dma_server: one instance with MEM_LAT=1 and one
// with MEM_LAT=2 share stimulus; each has its own memory model that returns
// a select-dependent scramble of the address exactly MEM_LAT cycles after
// the select, and garbage otherwise.
module tb_audio_dma_server;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        line_start;
  logic        slot;
  logic [3:0]  fetch;
  logic [3:0]  tile;
  logic [63:0] addr;

  logic        ds1, ds2;
  logic [3:0]  ack1, ack2;
  logic [63:0] word1, word2;
  logic [15:0] stat1, stat2;

  int n_cmp  = 0;
  int n_fail = 0;

  audio_dma_server_if m1();
  audio_dma_server_if m2();

  always #5 clk = ~clk;

  audio_dma_server #(.NCHAN(4), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset_n_i(reset_n), .audio_enable_i(en),
    .line_start_i(line_start), .dma_slot_i(slot), .dma_start_o(ds1),
    .chan_fetch_i(fetch), .chan_tile_i(tile), .chan_addr_i(addr),
    .chan_ack_o(ack1), .chan_word_o(word1), .mem(m1.master),
    .stat_miss_o(stat1)
  );

  audio_dma_server #(.NCHAN(4), .MEM_LAT(2)) dut2 (
    .clk(clk), .reset_n_i(reset_n), .audio_enable_i(en),
    .line_start_i(line_start), .dma_slot_i(slot), .dma_start_o(ds2),
    .chan_fetch_i(fetch), .chan_tile_i(tile), .chan_addr_i(addr),
    .chan_ack_o(ack2), .chan_word_o(word2), .mem(m2.master),
    .stat_miss_o(stat2)
  );

  function automatic logic [15:0] memf(input logic [15:0] a, input logic t);
    return a ^ (t ? 16'h0F0F : 16'hB76E);
  endfunction

  logic [15:0] q1, q2a, q2b;

  always @(posedge clk) begin
    q1  <= (m1.vram_sel_o || m1.tile_sel_o) ? memf(m1.mem_addr_o, m1.tile_sel_o) : 16'hDEAD;
    q2a <= (m2.vram_sel_o || m2.tile_sel_o) ? memf(m2.mem_addr_o, m2.tile_sel_o) : 16'hDEAD;
    q2b <= q2a;
  end

  assign m1.mem_data_i = q1;
  assign m2.mem_data_i = q2b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; en = 1'b0; line_start = 1'b0; slot = 1'b0;
    fetch = '0; tile = '0; addr = '0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b1; line_start = 1'b1; slot = 1'b1;
    fetch = 4'hF; tile = 4'h0; addr = 64'h4444_3333_2222_1111;
    tick(); tick();
    n_cmp++; if (ds1 !== 1'b0) begin n_fail++; $display("FAIL reset_dma_start got %b want 0", ds1); end
    n_cmp++; if (ack1 !== 4'h0) begin n_fail++; $display("FAIL reset_ack got %h want 0", ack1); end
    n_cmp++; if (word1 !== 64'h0) begin n_fail++; $display("FAIL reset_word got %h want 0", word1); end
    n_cmp++; if (m1.vram_sel_o !== 1'b0 || m1.tile_sel_o !== 1'b0) begin n_fail++; $display("FAIL reset_sel got %b%b want 00", m1.vram_sel_o, m1.tile_sel_o); end
    n_cmp++; if (m1.mem_addr_o !== 16'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", m1.mem_addr_o); end
    n_cmp++; if (stat1 !== 16'h0) begin n_fail++; $display("FAIL reset_stat got %h want 0", stat1); end
    do_reset();
  endtask

  task automatic test_single();
    int busy;
    do_reset();
    en = 1'b1; slot = 1'b1; tile = 4'b0000; addr[15:0] = 16'h1234; fetch = 4'b0001;
    tick();
    n_cmp++; if (m1.vram_sel_o !== 1'b1 || m1.tile_sel_o !== 1'b0) begin n_fail++; $display("FAIL single_issue_sel got %b%b want 10", m1.vram_sel_o, m1.tile_sel_o); end
    n_cmp++; if (m1.mem_addr_o !== 16'h1234) begin n_fail++; $display("FAIL single_issue_addr got %h want 1234", m1.mem_addr_o); end
    tick();
    n_cmp++; if (m1.vram_sel_o !== 1'b0 || ack1 !== 4'h0) begin n_fail++; $display("FAIL single_ackstate got sel %b ack %h want 0 0", m1.vram_sel_o, ack1); end
    tick();
    n_cmp++; if (ack1 !== 4'b0001) begin n_fail++; $display("FAIL single_ack got %b want 0001", ack1); end
    n_cmp++; if (word1[15:0] !== 16'hA55A) begin n_fail++; $display("FAIL single_word got %h want a55a", word1[15:0]); end
    tick();
    n_cmp++; if (ack1 !== 4'h0 || m1.vram_sel_o !== 1'b0) begin n_fail++; $display("FAIL single_no_reserve got ack %h sel %b want 0 0", ack1, m1.vram_sel_o); end
    fetch = 4'b0000;
    busy = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m1.vram_sel_o || m1.tile_sel_o || (ack1 != 4'h0)) busy++;
    end
    n_cmp++; if (busy !== 0) begin n_fail++; $display("FAIL single_quiet got %0d busy cycles want 0", busy); end
  endtask

  task automatic test_round_robin();
    int order[8];
    int n_acks;
    logic [3:0] last;
    do_reset();
    en = 1'b1; slot = 1'b1; tile = 4'b0000;
    addr = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
    fetch = 4'b1111;
    n_acks = 0; last = '0;
    for (int c = 0; c < 8; c++) order[c] = -1;
    for (int cyc = 0; cyc < 40 && n_acks < 4; cyc++) begin
      tick();
      fetch = fetch & ~last;
      last  = ack1;
      for (int c = 0; c < 4; c++) if (ack1[c]) begin
        if (n_acks < 8) order[n_acks] = c;
        n_acks++;
      end
    end
    tick(); fetch = fetch & ~last;
    n_cmp++; if (n_acks !== 4) begin n_fail++; $display("FAIL rr_count got %0d want 4", n_acks); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (order[i] !== i) begin n_fail++; $display("FAIL rr_order[%0d] got %0d want %0d", i, order[i], i); end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (word1[16*i +: 16] !== memf(addr[16*i +: 16], 1'b0)) begin n_fail++; $display("FAIL rr_word[%0d] got %h want %h", i, word1[16*i +: 16], memf(addr[16*i +: 16], 1'b0)); end
    end
    fetch = 4'b0101;
    n_acks = 0; last = '0;
    for (int c = 0; c < 8; c++) order[c] = -1;
    for (int cyc = 0; cyc < 40 && n_acks < 2; cyc++) begin
      tick();
      fetch = fetch & ~last;
      last  = ack1;
      for (int c = 0; c < 4; c++) if (ack1[c]) begin
        if (n_acks < 8) order[n_acks] = c;
        n_acks++;
      end
    end
    tick(); fetch = fetch & ~last;
    n_cmp++; if (order[0] !== 0 || order[1] !== 2) begin n_fail++; $display("FAIL rr_reraise got %0d,%0d want 0,2", order[0], order[1]); end
    fetch = 4'b0000;
  endtask

  task automatic test_slot_gating();
    do_reset();
    en = 1'b1; slot = 1'b0; tile = 4'b0010; addr[31:16] = 16'h0040; fetch = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (m1.vram_sel_o !== 1'b0 || m1.tile_sel_o !== 1'b0) begin n_fail++; $display("FAIL slot_closed[%0d] got %b%b want 00", i, m1.vram_sel_o, m1.tile_sel_o); end
    end
    slot = 1'b1;
    tick();
    n_cmp++; if (m1.tile_sel_o !== 1'b1 || m1.vram_sel_o !== 1'b0) begin n_fail++; $display("FAIL slot_open_sel got vram %b tile %b want 0 1", m1.vram_sel_o, m1.tile_sel_o); end
    n_cmp++; if (m1.mem_addr_o !== 16'h0040) begin n_fail++; $display("FAIL slot_open_addr got %h want 0040", m1.mem_addr_o); end
    tick(); tick();
    n_cmp++; if (ack1 !== 4'b0010 || word1[31:16] !== 16'h0F4F) begin n_fail++; $display("FAIL slot_ack got ack %b word %h want 0010 0f4f", ack1, word1[31:16]); end
    tick();
    fetch = 4'b0000;
  endtask

  task automatic test_drop_after_grant();
    do_reset();
    en = 1'b1; slot = 1'b1; tile = 4'b0000; addr[47:32] = 16'h0777; fetch = 4'b0100;
    tick();
    fetch = 4'b0000;
    tick();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    n_cmp++; if (ack1 !== 4'b0100) begin n_fail++; $display("FAIL drop_ack got %b want 0100", ack1); end
    n_cmp++; if (word1[47:32] !== 16'hB019) begin n_fail++; $display("FAIL drop_word got %h want b019", word1[47:32]); end
    n_cmp++; if (ds1 !== 1'b1) begin n_fail++; $display("FAIL ack_with_line_start got %b want 1", ds1); end
  endtask

  task automatic test_lat2_abort();
    do_reset();
    en = 1'b1; slot = 1'b1; tile = 4'b0000; addr[15:0] = 16'h0100; fetch = 4'b0001;
    tick();
    n_cmp++; if (m2.vram_sel_o !== 1'b1 || m2.mem_addr_o !== 16'h0100) begin n_fail++; $display("FAIL lat2_issue got sel %b addr %h want 1 0100", m2.vram_sel_o, m2.mem_addr_o); end
    tick();
    n_cmp++; if (m2.vram_sel_o !== 1'b0 || ack2 !== 4'h0) begin n_fail++; $display("FAIL lat2_wait got sel %b ack %h want 0 0", m2.vram_sel_o, ack2); end
    tick();
    n_cmp++; if (ack2 !== 4'h0) begin n_fail++; $display("FAIL lat2_early_ack got %h want 0", ack2); end
    tick();
    n_cmp++; if (ack2 !== 4'b0001 || word2[15:0] !== 16'hB66E) begin n_fail++; $display("FAIL lat2_ack got ack %b word %h want 0001 b66e", ack2, word2[15:0]); end
    tick();
    fetch = 4'b0000;
    tick();
    addr[15:0] = 16'h0200; fetch = 4'b0001;
    tick();
    tick();
    en = 1'b0;
    tick();
    n_cmp++; if (ack2 !== 4'h0 || m2.vram_sel_o !== 1'b0) begin n_fail++; $display("FAIL abort_no_ack got ack %h sel %b want 0 0", ack2, m2.vram_sel_o); end
    tick();
    n_cmp++; if (ack2 !== 4'h0 || word2[15:0] !== 16'hB66E) begin n_fail++; $display("FAIL abort_word_held got ack %h word %h want 0 b66e", ack2, word2[15:0]); end
    en = 1'b1;
    tick();
    n_cmp++; if (m2.vram_sel_o !== 1'b1 || m2.mem_addr_o !== 16'h0200) begin n_fail++; $display("FAIL abort_back_idle got sel %b addr %h want 1 0200", m2.vram_sel_o, m2.mem_addr_o); end
    tick(); tick(); tick();
    n_cmp++; if (ack2 !== 4'b0001 || word2[15:0] !== 16'hB56E) begin n_fail++; $display("FAIL abort_retry_ack got ack %b word %h want 0001 b56e", ack2, word2[15:0]); end
    tick();
    fetch = 4'b0000;
  endtask

  task automatic test_line_strobe();
    do_reset();
    en = 1'b1; line_start = 1'b1;
    tick();
    line_start = 1'b0;
    n_cmp++; if (ds1 !== 1'b1) begin n_fail++; $display("FAIL line_strobe_on got %b want 1", ds1); end
    tick();
    n_cmp++; if (ds1 !== 1'b0) begin n_fail++; $display("FAIL line_strobe_off got %b want 0", ds1); end
    en = 1'b0; line_start = 1'b1;
    tick();
    line_start = 1'b0;
    n_cmp++; if (ds1 !== 1'b0) begin n_fail++; $display("FAIL line_strobe_disabled got %b want 0", ds1); end
  endtask

  task automatic test_stats();
    logic [15:0] exp_miss;
`ifdef AUDIO_DMA_STATS_EN
    exp_miss = 16'd3;
`else
    exp_miss = 16'd0;
`endif
    do_reset();
    en = 1'b1; slot = 1'b0; fetch = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      line_start = 1'b1; tick();
      line_start = 1'b0; tick();
    end
    n_cmp++; if (stat1 !== exp_miss) begin n_fail++; $display("FAIL stats_miss got %h want %h", stat1, exp_miss); end
    fetch = 4'b0000;
    line_start = 1'b1; tick();
    line_start = 1'b0; tick();
    n_cmp++; if (stat1 !== exp_miss) begin n_fail++; $display("FAIL stats_no_pending got %h want %h", stat1, exp_miss); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1; slot = 1'b1; tile = 4'b0000; addr[15:0] = 16'h1234; fetch = 4'b0001;
    tick();
    reset_n = 1'b0;
    tick();
    n_cmp++; if (m1.vram_sel_o !== 1'b0 || ack1 !== 4'h0) begin n_fail++; $display("FAIL reset_mid_sel got sel %b ack %h want 0 0", m1.vram_sel_o, ack1); end
    tick();
    n_cmp++; if (ack1 !== 4'h0 || word1 !== 64'h0) begin n_fail++; $display("FAIL reset_mid_ack got ack %h word %h want 0 0", ack1, word1); end
    reset_n = 1'b1; fetch = 4'b0000;
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired: %0d compared / %0d mismatched", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_slot_gating();
    test_drop_after_grant();
    test_lat2_abort();
    test_line_strobe();
    test_stats();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
